// File: rtl/mux_check_sequencer.sv
// mux_check_sequencer: exhaustive clocked sweep of {a,b,c} checking z against (c & b) | (a & ~c).
module mux_check_sequencer #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic [3:0] pass_cnt,
  output logic [3:0] fail_cnt,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid,
  output logic       all_pass
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  localparam logic [3:0] LIM = SETTLE == 0 ? 4'd1 : 4'(SETTLE);
  state_t state, state_n;
  logic [2:0] i, i_n;
  logic [3:0] cnt, cnt_n;
  logic exp_z, mis;
  assign exp_z = (c & b) | (a & ~c);
  // 4-state compare so an X/Z on z is scored as a failure
  assign mis = z !== exp_z;
  assign busy = state == APPLY || state == CHECK;
  assign done = state == DONE;
  assign all_pass = done && fail_cnt == 4'd0;
  always_comb begin
    state_n = state;
    i_n = i;
    cnt_n = '0;
    case (state)
      IDLE: begin
        state_n = start ? APPLY : IDLE;
        i_n = '0;
      end
      APPLY: begin
        state_n = cnt == LIM - 4'd1 ? CHECK : APPLY;
        cnt_n = cnt == LIM - 4'd1 ? 4'd0 : cnt + 4'd1;
      end
      CHECK: begin
        state_n = i == 3'd7 ? DONE : APPLY;
        i_n = i + 3'd1;
      end
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i <= '0;
      cnt <= '0;
      {a, b, c} <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state <= state_n;
      i <= i_n;
      cnt <= cnt_n;
      {a, b, c} <= (state_n == APPLY || state_n == CHECK) ? i_n : 3'b000;
      if (state == IDLE && start) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
        first_fail_vec <= '0;
        first_fail_valid <= 1'b0;
      end else if (state == CHECK) begin
        if (mis) begin
          fail_cnt <= fail_cnt + 4'd1;
          if (!first_fail_valid) begin
            first_fail_vec <= {a, b, c};
            first_fail_valid <= 1'b1;
          end
        end else begin
          pass_cnt <= pass_cnt + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_check_sequencer.sv
// tb_mux_check_sequencer: scoreboard bench driving two sequencers (SETTLE=1 and SETTLE=3) against fault tables.
module tb_mux_check_sequencer;
  logic clk = 0;
  logic rst = 1;
  logic st[2];
  logic zz[2], aa[2], bb[2], cc[2], bz[2], dn[2], ap[2], fv[2];
  logic [3:0] pc[2], fc[2];
  logic [2:0] ffv[2];
  logic [7:0] tbl = 8'h00;
  int cyc = 0;
  int errs = 0;
  int checks = 0;

  typedef struct {
    int d;
    int s0;
    int per;
    logic [3:0] pc;
    logic [3:0] fc;
    logic [2:0] ffv;
    logic fv;
  } run_t;
  run_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign zz[0] = tbl[{aa[0], bb[0], cc[0]}];
  assign zz[1] = tbl[{aa[1], bb[1], cc[1]}];

  mux_check_sequencer #(.SETTLE(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .a(aa[0]), .b(bb[0]), .c(cc[0]), .z(zz[0]),
    .busy(bz[0]), .done(dn[0]), .pass_cnt(pc[0]), .fail_cnt(fc[0]),
    .first_fail_vec(ffv[0]), .first_fail_valid(fv[0]), .all_pass(ap[0])
  );
  mux_check_sequencer #(.SETTLE(3)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(aa[1]), .b(bb[1]), .c(cc[1]), .z(zz[1]),
    .busy(bz[1]), .done(dn[1]), .pass_cnt(pc[1]), .fail_cnt(fc[1]),
    .first_fail_vec(ffv[1]), .first_fail_valid(fv[1]), .all_pass(ap[1])
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  // Reference: the datapath is a 2:1 mux selecting b when c=1, a when c=0.
  function automatic run_t mk(input int d, input int s0, input logic [7:0] f);
    run_t r;
    logic [2:0] v;
    logic e;
    r.d = d;
    r.s0 = s0;
    r.per = (d == 0 ? 1 : 3) + 1;
    r.pc = 0;
    r.fc = 0;
    r.ffv = 0;
    r.fv = 0;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      e = v[0] ? v[1] : v[2];
      if (f[k] !== e) begin
        r.fc++;
        if (!r.fv) begin
          r.ffv = v;
          r.fv = 1;
        end
      end else begin
        r.pc++;
      end
    end
    return r;
  endfunction

  run_t h;
  int t, md;
  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      h = q[0];
      md = h.d;
      t = cyc - h.s0;
      if (t >= 1 && t <= 8 * h.per) begin
        chk("walk", {aa[md], bb[md], cc[md], bz[md], dn[md]}, {3'((t - 1) / h.per), 1'b1, 1'b0});
        if (t == 1) chk("clear", {pc[md], fc[md], ffv[md], fv[md]}, 12'h0);
      end else if (t == 8 * h.per + 1) begin
        chk("done_out", {aa[md], bb[md], cc[md], bz[md], dn[md], ap[md]}, {3'b000, 1'b0, 1'b1, h.fc == 0});
        chk("results", {pc[md], fc[md], ffv[md], fv[md]}, {h.pc, h.fc, h.ffv, h.fv});
        void'(q.pop_front());
      end
    end else if (!rst) begin
      for (int k = 0; k < 2; k++)
        chk("idle", {aa[k], bb[k], cc[k], bz[k], dn[k], ap[k]}, 6'h0);
    end
  end

  task automatic go(input int d, input logic [7:0] f);
    tbl = f;
    st[d] = 1;
    q.push_back(mk(d, cyc, f));
    @(negedge clk);
    st[d] = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errs++;
      $display("FAIL drain: run did not complete, %0d pending", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  logic [7:0] inv, fx;
  initial begin
    st[0] = 0;
    st[1] = 0;
    for (int k = 0; k < 8; k++) inv[k] = k[0] ? k[2] : k[1];
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset", {aa[k], bb[k], cc[k], bz[k], dn[k], ap[k], pc[k], fc[k], ffv[k], fv[k]}, 0);
    rst = 0;
    @(negedge clk);
    go(0, 8'b1110_0100);
    drain();
    go(0, 8'h00);
    drain();
    go(0, 8'hFF);
    drain();
    go(0, inv);
    drain();
    fx = 8'b1110_0100;
    fx[6] = 1'bx;
    go(0, fx);
    drain();
    // SETTLE=3: stray start mid-run is ignored, start right after DONE launches a fresh run
    go(1, 8'h00);
    repeat (4) @(negedge clk);
    st[1] = 1;
    @(negedge clk);
    st[1] = 0;
    repeat (28) @(negedge clk);
    go(1, 8'b1110_0100);
    drain();
    // reset mid-run aborts without a done pulse
    go(0, 8'hFF);
    repeat (7) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    void'(q.pop_back());
    @(negedge clk);
    @(negedge clk);
    chk("abort", {aa[0], bb[0], cc[0], bz[0], dn[0], ap[0], pc[0], fc[0], ffv[0], fv[0]}, 0);
    rst = 0;
    repeat (20) @(negedge clk);
    go(0, 8'b1110_0100);
    drain();
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go(r % 2, 8'($urandom));
      drain();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
